// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between two requesters
module sram_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int PRIO_MODE  = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ADDR,
   output logic [DATA_WIDTH-1:0] DATA,
   output logic                  cen,
   output logic                  we,
   input  logic [DATA_WIDTH-1:0] Q
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic          last;
   logic [CW-1:0] starve;
   logic          win1;
   logic          xfer;
   logic          sel_we;
   logic          s1_v, s1_p, s2_v, s2_p;
   // grant: port 1 wins when alone, or on a tie when it is its turn / it is starving
   always_comb begin
      win1   = (PRIO_MODE != 0) ? (req1 && (!req0 || starve == CW'(STARVE_MAX)))
                                : (req1 && (!req0 || !last));
      ack1   = win1;
      ack0   = req0 && !win1;
      xfer   = req0 || req1;
      sel_we = win1 ? we1 : we0;
   end
   // SRAM command register, round-robin pointer and starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ADDR   <= '0;
         DATA   <= '0;
         cen    <= 1'b0;
         we     <= 1'b0;
         last   <= 1'b1;
         starve <= '0;
      end else begin
         cen    <= xfer;
         we     <= xfer && sel_we;
         starve <= (req1 && !win1) ? ((starve == CW'(STARVE_MAX)) ? starve : starve + CW'(1)) : '0;
         if (xfer) begin
            ADDR <= win1 ? addr1 : addr0;
            DATA <= win1 ? wdata1 : wdata0;
            last <= win1;
         end
      end
   end
   // two-stage read tracking matching the SRAM's registered-Q latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_p    <= 1'b0;
         s2_v    <= 1'b0;
         s2_p    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         s1_v    <= xfer && !sel_we;
         s1_p    <= win1;
         s2_v    <= s1_v;
         s2_p    <= s1_p;
         rvalid0 <= s2_v && !s2_p;
         rvalid1 <= s2_v && s2_p;
         if (s2_v && !s2_p) rdata0 <= Q;
         if (s2_v && s2_p) rdata1 <= Q;
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of arbitration, SRAM command and read return
module tb_sram_port_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [9:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, rvalid0, rvalid1, cen, we;
   logic [7:0] rdata0, rdata1, DATA, Q;
   logic [9:0] ADDR;
   logic       ack0f, ack1f, rvalid0f, rvalid1f, cenf, wef;
   logic [7:0] rdata0f, rdata1f, DATAf;
   logic [9:0] ADDRf;
   logic [7:0] mem [0:1023];
   int         checks = 0;
   int         failures = 0;

   sram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .ADDR(ADDR), .DATA(DATA),
      .cen(cen), .we(we), .Q(Q)
   );

   sram_port_arbiter #(.PRIO_MODE(1), .STARVE_MAX(4)) dut_f (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0f), .ack1(ack1f), .rvalid0(rvalid0f), .rvalid1(rvalid1f),
      .rdata0(rdata0f), .rdata1(rdata1f), .ADDR(ADDRf), .DATA(DATAf),
      .cen(cenf), .we(wef), .Q(Q)
   );

   always #5 clk = ~clk;

   // single-port SRAM with registered read data
   always @(posedge clk) begin
      if (cen) begin
         if (we) mem[ADDR] <= DATA;
         else Q <= mem[ADDR];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset held low for three cycles
      repeat (3) step();
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_data", DATA, 0);
      chk("rst_cen", cen, 0);
      chk("rst_we", we, 0);
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      #1;
      chk("first_tie_ack0", ack0, 1);
      chk("first_tie_ack1", ack1, 0);
      req0 = 1'b0; req1 = 1'b0;
      step();
      // port 0 write then read of the same address
      req0 = 1'b1; we0 = 1'b1; addr0 = 10'h012; wdata0 = 8'hA5;
      #1;
      chk("wr_ack0", ack0, 1);
      step();
      chk("wr_cen", cen, 1);
      chk("wr_we", we, 1);
      chk("wr_addr", ADDR, 10'h012);
      chk("wr_data", DATA, 8'hA5);
      we0 = 1'b0;
      #1;
      chk("rd_ack0", ack0, 1);
      step();
      chk("rd_cen", cen, 1);
      chk("rd_we", we, 0);
      req0 = 1'b0;
      step();
      chk("rd_t1_rvalid0", rvalid0, 0);
      step();
      chk("rd_t2_rvalid0", rvalid0, 1);
      chk("rd_t2_rdata0", rdata0, 8'hA5);
      chk("rd_t2_rvalid1", rvalid1, 0);
      step();
      chk("rd_t3_rvalid0", rvalid0, 0);
      chk("idle_cen", cen, 0);
      // port 1 writes 16 consecutive cycles
      for (int k = 0; k < 16; k++) begin
         req1 = 1'b1; we1 = 1'b1; addr1 = 10'(k); wdata1 = 8'(k * 7 + 3);
         #1;
         chk("burst_ack1", ack1, 1);
         step();
         chk("burst_cen", cen, 1);
         chk("burst_we", we, 1);
         chk("burst_addr", ADDR, k);
      end
      req1 = 1'b0;
      step();
      chk("burst_idle_cen", cen, 0);
      chk("burst_idle_we", we, 0);
      chk("burst_idle_addr_hold", ADDR, 15);
      chk("burst_idle_data_hold", DATA, 8'(15 * 7 + 3));
      // port 1 reads back addresses 0..15 back to back
      for (int k = 0; k < 18; k++) begin
         req1 = (k < 16); we1 = 1'b0; addr1 = 10'(k);
         #1;
         if (k < 16) chk("rb_ack1", ack1, 1);
         step();
         if (k >= 2) begin
            chk("rb_rvalid1", rvalid1, 1);
            chk("rb_rdata1", rdata1, 8'((k - 2) * 7 + 3));
            chk("rb_rvalid0", rvalid0, 0);
         end
      end
      step();
      chk("rb_end_rvalid1", rvalid1, 0);
      // preload addr 1 via port 0 and addr 2 via port 1 (leaves last=1)
      req0 = 1'b1; we0 = 1'b1; addr0 = 10'd1; wdata0 = 8'h11;
      step();
      req0 = 1'b0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'd2; wdata1 = 8'h22;
      step();
      req1 = 1'b0;
      step();
      // round-robin with both requesters reading continuously
      for (int k = 0; k < 10; k++) begin
         req0 = (k < 8); req1 = (k < 8); we0 = 1'b0; we1 = 1'b0; addr0 = 10'd1; addr1 = 10'd2;
         #1;
         if (k < 8) begin
            chk("rr_ack0", ack0, (k % 2 == 0));
            chk("rr_ack1", ack1, (k % 2 == 1));
         end
         step();
         if (k >= 2) begin
            chk("rr_rvalid0", rvalid0, ((k - 2) % 2 == 0));
            chk("rr_rvalid1", rvalid1, ((k - 2) % 2 == 1));
            if ((k - 2) % 2 == 0) chk("rr_rdata0", rdata0, 8'h11);
            else chk("rr_rdata1", rdata1, 8'h22);
         end else begin
            chk("rr_pre_rvalid0", rvalid0, 0);
            chk("rr_pre_rvalid1", rvalid1, 0);
         end
      end
      step();
      // fixed priority with starvation relief on the second instance
      for (int k = 0; k < 12; k++) begin
         req0 = 1'b1; req1 = 1'b1;
         #1;
         chk("fp_ack1", ack1f, (k % 5 == 4));
         chk("fp_ack0", ack0f, (k % 5 != 4));
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) step();
      // reset during an in-flight port 1 read
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'd2;
      #1;
      chk("rst_mid_ack1", ack1, 1);
      step();
      req1 = 1'b0;
      chk("rst_mid_cen", cen, 1);
      #3;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_mid_rvalid1", rvalid1, 0);
         chk("rst_mid_rdata1", rdata1, 0);
         chk("rst_mid_cen_idle", cen, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
